// File: rtl/board_io_arbiter.sv
// board_io_arbiter
//   Shares the four board output banks between a host write port and a local
//   switch-driven view. A debounced press on button 0 hands the outputs to the
//   local view. A second press, or an inactivity timeout, hands them back. On
//   hand-back the outputs are restored from shadow copies of the host writes.
//
// Ports
//   clk_clk        : single clock, rising edge
//   reset_reset_n  : asynchronous active-low reset
//   host_wr_valid  : host write request
//   host_wr_ready  : write accepted this cycle when valid & ready
//   host_wr_sel    : target select, 0 display_right, 1 display_left,
//                    2 leds_red, 3 leds_green
//   host_wr_data   : write data
//   push_buttons   : raw buttons; only bit 0 (active-low) is used
//   inport         : raw 16-bit switch bank
//   display_right, display_left, leds_red, leds_green : registered outputs
//   owner          : 0 = host owns the outputs, 1 = local view owns them
//
// state   | meaning
// HOST    | outputs follow host writes, ready high
// LOCAL   | outputs show the switch view, host writes go to the shadows only
// RETURN  | one cycle: outputs reload from the shadows, ready low

module board_io_arbiter #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        host_wr_valid,
    output logic        host_wr_ready,
    input  logic [1:0]  host_wr_sel,
    input  logic [31:0] host_wr_data,
    input  logic [31:0] push_buttons,
    input  logic [15:0] inport,
    output logic [31:0] display_right,
    output logic [31:0] display_left,
    output logic [31:0] leds_red,
    output logic [31:0] leds_green,
    output logic        owner
);

    typedef enum logic [1:0] {ST_HOST, ST_LOCAL, ST_RETURN} state_t;

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int IDLE_W = $clog2(HOLD_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(HOLD_CYCLES - 1);

    state_t             state, state_next;
    logic               btn_meta, btn_sync, btn_deb, press;
    logic [15:0]        inport_meta, inport_sync;
    logic [DB_W-1:0]    db_cnt;
    logic [IDLE_W-1:0]  idle_cnt;
    logic               ready_en;
    logic               accept;
    logic [31:0]        shadow [4];
    logic [31:0]        out_q  [4];

    wire unused_buttons = ^push_buttons[31:1];

    // Button sync flops reset to 1 so a released button is the idle level.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            btn_meta    <= 1'b1;
            btn_sync    <= 1'b1;
            inport_meta <= '0;
            inport_sync <= '0;
        end else begin
            btn_meta    <= push_buttons[0];
            btn_sync    <= btn_meta;
            inport_meta <= inport;
            inport_sync <= inport_meta;
        end
    end

    // The counter runs only while the synchronized level differs from the
    // debounced one; a bounce back to the debounced level restarts it.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            btn_deb <= 1'b1;
            db_cnt  <= '0;
            press   <= 1'b0;
        end else begin
            press <= 1'b0;
            if (btn_sync == btn_deb) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_deb <= btn_sync;
                db_cnt  <= '0;
                press   <= ~btn_sync;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state    <= ST_HOST;
            ready_en <= 1'b0;
        end else begin
            state    <= state_next;
            ready_en <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_HOST:   if (press) state_next = ST_LOCAL;
            ST_LOCAL:  if (press || idle_cnt == IDLE_LAST) state_next = ST_RETURN;
            ST_RETURN: state_next = ST_HOST;
            default:   state_next = ST_HOST;
        endcase
    end

    assign host_wr_ready = ready_en & (state != ST_RETURN);
    assign accept        = host_wr_valid & host_wr_ready;
    assign owner         = (state == ST_LOCAL);

    // Held at zero outside LOCAL, so entering LOCAL always starts from zero.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            idle_cnt <= '0;
        end else if (state != ST_LOCAL || press) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_LAST) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < 4; i++) shadow[i] <= '0;
        end else if (accept) begin
            shadow[host_wr_sel] <= host_wr_data;
        end
    end

    // Outputs are loaded from the state being left: HOST tracks writes,
    // LOCAL tracks the switches, RETURN restores the shadows.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < 4; i++) out_q[i] <= '0;
        end else begin
            case (state)
                ST_HOST: begin
                    if (state_next == ST_LOCAL) begin
                        out_q[0] <= {16'h0, inport_sync};
                        out_q[1] <= 32'h0;
                        out_q[2] <= {16'h0, inport_sync};
                        out_q[3] <= 32'h1;
                    end else if (accept) begin
                        out_q[host_wr_sel] <= host_wr_data;
                    end
                end
                ST_LOCAL: begin
                    out_q[0] <= {16'h0, inport_sync};
                    out_q[1] <= 32'h0;
                    out_q[2] <= {16'h0, inport_sync};
                    out_q[3] <= 32'h1;
                end
                ST_RETURN: begin
                    for (int i = 0; i < 4; i++) out_q[i] <= shadow[i];
                end
                default: ;
            endcase
        end
    end

    assign display_right = out_q[0];
    assign display_left  = out_q[1];
    assign leds_red      = out_q[2];
    assign leds_green    = out_q[3];

endmodule
